// File: rtl/serial_magnitude_comparator_if.sv
// Handshake and result bundle for the bit-serial magnitude comparator.
// The master modport drives the request; the slave modport is the comparator side.
interface serial_magnitude_comparator_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             a_gt_b;
  logic             a_lt_b;
  logic             a_eq_b;
  logic             ser_a;
  logic             ser_b;
  logic             ser_valid;

  modport master (
    output start, a, b,
    input  busy, done, a_gt_b, a_lt_b, a_eq_b, ser_a, ser_b, ser_valid
  );

  modport slave (
    input  start, a, b,
    output busy, done, a_gt_b, a_lt_b, a_eq_b, ser_a, ser_b, ser_valid
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator: walks two captured operands one bit
// per clock and stops at the first differing bit, reporting gt/lt/eq with a done pulse.
module serial_magnitude_comparator #(
  parameter int unsigned WIDTH = 8
) (
  input logic                         clk,
  input logic                         rst,
  serial_magnitude_comparator_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;

  logic msb_a, msb_b;
  assign msb_a = sh_a_q[WIDTH-1];
  assign msb_b = sh_b_q[WIDTH-1];

  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          sh_a_d  = bus.a;
          sh_b_d  = bus.b;
          cnt_d   = CntW'(WIDTH - 1);
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        if (msb_a != msb_b) begin
          gt_d    = msb_a;
          lt_d    = msb_b;
          state_d = StDone;
        end else if (cnt_q == '0) begin
          eq_d    = 1'b1;
          state_d = StDone;
        end else begin
          // Zero fill keeps the exposed ser_* stream deterministic past the operand.
          sh_a_d = sh_a_q << 1;
          sh_b_d = sh_b_q << 1;
          cnt_d  = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  logic busy;
  assign busy = (state_q == StShift);

  assign bus.busy      = busy;
  assign bus.done      = (state_q == StDone);
  assign bus.a_gt_b    = gt_q;
  assign bus.a_lt_b    = lt_q;
  assign bus.a_eq_b    = eq_q;
  assign bus.ser_a     = busy & msb_a;
  assign bus.ser_b     = busy & msb_b;
  assign bus.ser_valid = busy;

endmodule
